// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory with a fixed wait-state request/response handshake.
// Latency: rvalid pulses WAIT+1 cycles after the accepting edge; requests are spaced WAIT+2 cycles apart at best.
// Backpressure: ready is high only in IDLE; a req seen while busy is dropped, never queued.
// Optional feature: define DMEM_ALIGN_CHECK_EN to flag misaligned accesses (err=1, rdata=0, write suppressed).
module dmem_responder #(
  parameter int DEPTH = 64,
  parameter int WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  // Reload value for the wait counter; unused when WAIT is zero.
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT > 0) ? (WAIT - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [3:0]      wcnt;
  logic [3:0]      wcnt_nx;
  logic            accept;
  logic            resp_live;

  logic            we_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic            bad_q;

  logic [31:0]     mem [DEPTH];

  // Address bits outside the word index are intentionally ignored (aliasing).
  logic            unused_addr;
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};

  assign accept = (state == ST_IDLE) && req;

  // State register and wait counter; reset wins over any simultaneous request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      wcnt  <= 4'd0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
    end
  end

  // Next-state: IDLE -> (WAIT x WAIT cycles) -> RESP for one cycle -> IDLE.
  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (WAIT > 0) begin
            state_nx = ST_WAIT;
            wcnt_nx  = WAIT_LOAD;
          end else begin
            state_nx = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (wcnt == 4'd0) begin
          state_nx = ST_RESP;
        end else begin
          wcnt_nx = wcnt - 4'd1;
        end
      end
      ST_RESP: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
        wcnt_nx  = 4'd0;
      end
    endcase
  end

  // Capture the access on the accepting edge; nothing is captured while busy.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      we_q    <= we;
      idx_q   <= addr[AW+1:2];
      wdata_q <= wdata;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  // Misalignment flag travels with the access so RESP can report it.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      bad_q <= (addr[1:0] != 2'b00);
    end
  end
`else
  assign bad_q = 1'b0;
`endif

  // Write commits on the edge that ends RESP; an aborting reset suppresses it.
  always_ff @(posedge clk) begin
    if (!reset && (state == ST_RESP) && we_q && !bad_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  // Response outputs exist only in RESP; a reset in that cycle aborts the pulse.
  assign resp_live = (state == ST_RESP) && !reset;
  assign ready     = (state == ST_IDLE);
  assign rvalid    = resp_live;
  assign rdata     = (resp_live && !we_q && !bad_q) ? mem[idx_q] : 32'd0;

`ifdef DMEM_ALIGN_CHECK_EN
  assign err = resp_live && bad_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: reference model of the request/response protocol and memory,
// checked every cycle, plus literal expectations for the key scenarios.
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int WAIT  = 2;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk;
  logic        reset, req, we;
  logic [31:0] addr, wdata;
  logic        ready, rvalid, err;
  logic [31:0] rdata;

  logic        reset0, req0, we0;
  logic [31:0] addr0, wdata0;
  logic        ready0, rvalid0, err0;
  logic [31:0] rdata0;

  int checks = 0;
  int errors = 0;

  dmem_responder #(.DEPTH(DEPTH), .WAIT(WAIT)) u_dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .rvalid(rvalid), .rdata(rdata), .err(err)
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT(0)) u_dut0 (
    .clk(clk), .reset(reset0), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .ready(ready0), .rvalid(rvalid0), .rdata(rdata0), .err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mmem [DEPTH];
  int          cyc = 0;
  bit          pend = 1'b0;
  int          resp_cyc = 0;
  int          next_free = 0;
  bit          m_we, m_bad, exp_rv;
  int          m_idx;
  logic [31:0] m_wd, exp_rd;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 32'(DEPTH));
  endfunction

  // Outputs are compared mid-cycle against the protocol rules.
  always @(negedge clk) begin
    if (reset) begin
      pend      = 1'b0;
      next_free = cyc + 1;
    end else begin
      exp_rv = pend && (cyc == resp_cyc);
      exp_rd = (exp_rv && !m_we && !m_bad) ? mmem[m_idx] : 32'd0;
      check1("ready", ready, cyc >= next_free);
      check1("rvalid", rvalid, exp_rv);
      check32("rdata", rdata, exp_rd);
      check1("err", err, exp_rv && m_bad);
      if (exp_rv) begin
        if (m_we && !m_bad) mmem[m_idx] = m_wd;
        pend = 1'b0;
      end
      if (req && (cyc >= next_free)) begin
        m_we      = we;
        m_idx     = widx(addr);
        m_wd      = wdata;
        m_bad     = ALIGN && ((addr % 4) != 0);
        pend      = 1'b1;
        resp_cyc  = cyc + WAIT + 1;
        next_free = cyc + WAIT + 2;
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e, output int lat);
    int n;
    n = 0;
    while (!ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) check1("acc_ready_timeout", ready, 1'b1);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 1;
    while (!rvalid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rvalid) check1("acc_rvalid_timeout", rvalid, 1'b1);
    rd = rdata;
    e  = err;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd, a;
  logic        e;
  int          lat, cnt;

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
    reset0 = 1'b1; req0 = 1'b1; we0 = 1'b1; addr0 = 32'd0; wdata0 = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; reset0 = 1'b0;

    // WAIT=0 instance with req held high: accept, respond, accept, ...
    for (int k = 0; k < 8; k++) begin
      check1("w0_ready", ready0, (k % 2) == 0);
      check1("w0_rvalid", rvalid0, (k % 2) == 1);
      check32("w0_rdata", rdata0, 32'd0);
      check1("w0_err", err0, 1'b0);
      @(posedge clk); #1;
    end
    req0 = 1'b0;

    // Define every word so reads are predictable.
    for (int i = 0; i < DEPTH; i++) begin
      access(1'b1, 32'(i * 4), $urandom, rd, e, lat);
    end

    // Write then read back with latency check.
    access(1'b1, 32'h8, 32'hDEADBEEF, rd, e, lat);
    check32("wr8_lat", 32'(lat), 32'd3);
    check32("wr8_rdata", rd, 32'd0);
    check1("wr8_err", e, 1'b0);
    access(1'b0, 32'h8, 32'd0, rd, e, lat);
    check32("rd8_lat", 32'(lat), 32'd3);
    check32("rd8_rdata", rd, 32'hDEADBEEF);
    check1("rd8_err", e, 1'b0);

    // Address aliasing modulo 4*DEPTH bytes.
    access(1'b1, 32'h0, 32'h11111111, rd, e, lat);
    access(1'b0, 32'h100, 32'd0, rd, e, lat);
    check32("alias_rdata", rd, 32'h11111111);

    // Reset during WAIT aborts the write.
    access(1'b1, 32'h4, 32'hA5A50004, rd, e, lat);
    req = 1'b1; we = 1'b1; addr = 32'h4; wdata = 32'h55;
    @(posedge clk); #1;
    req = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check1("rst_ready", ready, 1'b1);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (rvalid) cnt++;
      @(posedge clk); #1;
    end
    check32("abort_rvalid_cnt", 32'(cnt), 32'd0);
    access(1'b0, 32'h4, 32'd0, rd, e, lat);
    check32("abort_rdata", rd, 32'hA5A50004);

    // Misaligned write.
    access(1'b1, 32'h6, 32'h12345678, rd, e, lat);
    check1("mis_err", e, ALIGN);
    check32("mis_lat", 32'(lat), 32'd3);
    access(1'b0, 32'h4, 32'd0, rd, e, lat);
    check32("mis_readback", rd, ALIGN ? 32'hA5A50004 : 32'h12345678);

    // Random traffic, including requests while busy and occasional resets.
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      a = $urandom;
      if (($urandom % 8) != 0) a[1:0] = 2'b00;
      req   = 1'($urandom);
      we    = 1'($urandom);
      addr  = a;
      wdata = $urandom;
      reset = (($urandom % 64) == 0);
    end
    @(posedge clk); #1;
    req = 1'b0; reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
- REQ-001: Parameter DEPTH, default 64, is the memory size in 32-bit words; SHALL be a power of two, range 4..1024.
- REQ-002: Parameter WAIT, default 2, is the number of wait-state cycles per access; range 0..15.
- REQ-003: clk  input  1  single clock; all state SHALL update on its rising edge.
- REQ-004: reset  input  1  synchronous, active-high reset.
- REQ-005: req  input  1  request valid from the datapath.
- REQ-006: we  input  1  access type: 1=write, 0=read.
- REQ-007: addr  input  32  byte address (the ALU result).
- REQ-008: wdata  input  32  write data (the rt register value).
- REQ-009: ready  output  1  responder can accept a request.
- REQ-010: rvalid  output  1  one-cycle pulse marking access completion.
- REQ-011: rdata  output  32  read data; valid only while rvalid=1.
- REQ-012: err  output  1  access error; valid only while rvalid=1.

Function
- REQ-013: States SHALL be IDLE, WAIT and RESP; ready SHALL be 1 only in IDLE.
- REQ-014: A request SHALL be accepted on a cycle with req=1 and ready=1; we, addr and wdata SHALL be latched on that edge.
- REQ-015: req while not in IDLE SHALL be ignored: not latched, not queued.
- REQ-016: After acceptance, the FSM SHALL go IDLE->WAIT if WAIT>0, otherwise IDLE->RESP.
- REQ-017: WAIT SHALL last exactly WAIT cycles, counted by a 4-bit down-counter, then go to RESP.
- REQ-018: RESP SHALL last exactly one cycle with rvalid=1, then return to IDLE.
- REQ-019: rvalid SHALL rise exactly WAIT+1 cycles after the acceptance cycle.
- REQ-020: Minimum spacing between accepted requests SHALL be WAIT+2 cycles.
- REQ-021: Word index SHALL be addr[log2(DEPTH)+1:2]; higher address bits are ignored, so addresses wrap and alias modulo 4*DEPTH bytes.
- REQ-022: A read SHALL drive rdata = mem[index] during RESP.
- REQ-023: A write SHALL commit wdata to mem[index] on the edge ending RESP; rdata SHALL be 0 for a write response.
- REQ-024: A read accepted after a write's RESP cycle SHALL return the newly written value.
- REQ-025: Outside RESP, rdata SHALL be 0 and err SHALL be 0.

Reset
- REQ-026: Reset SHALL, on the next edge, force IDLE, ready=1, rvalid=0, rdata=0, err=0 and clear the wait counter.
- REQ-027: Reset asserted in WAIT or RESP SHALL abort the access: no rvalid pulse and no memory write.
- REQ-028: Reset takes priority over a simultaneous req.
- REQ-029: Memory contents SHALL NOT be cleared by reset.

Configuration
- REQ-030: Macro DMEM_ALIGN_CHECK_EN SHALL gate alignment checking.
- REQ-031: With DMEM_ALIGN_CHECK_EN defined, an access with addr[1:0]!=0 SHALL:
  - complete with normal timing;
  - drive err=1 and rdata=0 during RESP;
  - suppress the memory write.
- REQ-032: With DMEM_ALIGN_CHECK_EN undefined, addr[1:0] SHALL be ignored and err SHALL be tied to 0.

Verification
- REQ-033: WAIT=2: write addr=0x8, wdata=0xDEADBEEF, then read addr=0x8 -> each rvalid arrives 3 cycles after acceptance; read rdata=0xDEADBEEF, err=0.
- REQ-034: WAIT=0: back-to-back req held high -> acceptances every 2 cycles; rvalid follows each acceptance by 1 cycle; ready=0 in RESP.
- REQ-035: DEPTH=64: write 0x11111111 to addr=0x0, read addr=0x100 -> rdata=0x11111111 (wrap-around alias).
- REQ-036: Reset pulsed in WAIT of a write of 0x55 to addr=0x4 -> no rvalid; a later read of addr=0x4 returns the prior value; ready=1 on the cycle after reset.
- REQ-037: DMEM_ALIGN_CHECK_EN defined: write addr=0x6 -> err=1 with rvalid; read addr=0x4 is unchanged.
- REQ-037 (cont.): DMEM_ALIGN_CHECK_EN undefined: the same write lands in word 1 and err=0.
